// File: rtl/lynx_tape_rec.sv
// rtl/lynx_tape_rec.sv - cassette MIC pulse-period decoder feeding a byte FIFO
`timescale 1ns/1ps
module lynx_tape_rec #(
    parameter int MIN_CYC    = 16,
    parameter int THR_CYC    = 200,
    parameter int GAP_CYC    = 4000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic        mic,
    output logic [7:0]  rec_data,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic        rec_gap,
    output logic        overflow,
    output logic [15:0] byte_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MIN_C   = 16'(MIN_CYC);
    localparam logic [15:0] THR_C   = 16'(THR_CYC);
    localparam logic [15:0] GAP_C   = 16'(GAP_CYC);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;

    state_t      r_state;
    logic        r_mic_s1;
    logic        r_mic_s2;
    logic        r_mic_d;
    logic        r_edge;
    logic        r_en_d;
    logic [15:0] r_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic        r_gap;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_overflow;
    logic [15:0]   r_byte_count;

    logic       w_en_rise;
    logic       w_bit;
    logic       w_take;
    logic [7:0] w_byte;
    logic       w_push;
    logic       w_full;
    logic       w_pop;
    logic       w_accept;

    assign w_en_rise = enable & ~r_en_d;
    assign w_bit     = (r_cnt >= THR_C);
    // A qualified edge in RUN: not a glitch and not already past the gap limit.
    assign w_take    = (r_state == ST_RUN) && enable && !w_en_rise && r_edge &&
                       (r_cnt >= MIN_C) && (r_cnt < GAP_C);
    assign w_byte    = {r_shift[6:0], w_bit};
    assign w_push    = w_take && (r_bitcnt == 3'd7);
    assign w_full    = (r_fill == DEPTH_C);
    assign w_pop     = rec_valid && rec_ready;
    assign w_accept  = w_push && (!w_full || w_pop);

    assign rec_valid  = (r_fill != '0);
    assign rec_data   = rec_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign rec_gap    = r_gap;
    assign overflow   = r_overflow;
    assign byte_count = r_byte_count;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mic_s1 <= 1'b0;
            r_mic_s2 <= 1'b0;
            r_mic_d  <= 1'b0;
            r_edge   <= 1'b0;
            r_en_d   <= 1'b0;
            r_cnt    <= 16'h0000;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_gap    <= 1'b0;
        end else begin
            r_mic_s1 <= mic;
            r_mic_s2 <= r_mic_s1;
            r_mic_d  <= r_mic_s2;
            r_edge   <= r_mic_s2 & ~r_mic_d;
            r_en_d   <= enable;
            r_gap    <= 1'b0;
            if (!enable) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 16'h0000;
                r_shift  <= 8'h00;
                r_bitcnt <= 3'd0;
            end else if (w_en_rise) begin
                r_state  <= ST_SYNC;
                r_cnt    <= 16'h0000;
                r_shift  <= 8'h00;
                r_bitcnt <= 3'd0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_SYNC: begin
                        if (r_edge) begin
                            r_cnt   <= 16'h0000;
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (r_cnt >= GAP_C) begin
                            r_gap    <= 1'b1;
                            r_state  <= ST_SYNC;
                            r_cnt    <= 16'h0000;
                            r_shift  <= 8'h00;
                            r_bitcnt <= 3'd0;
                        end else if (w_take) begin
                            r_cnt    <= 16'h0000;
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end else if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Storage needs no reset: rec_data is masked while the FIFO is empty.
    always_ff @(posedge clk_sys) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_overflow   <= 1'b0;
            r_byte_count <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_fill <= r_fill + (AW+1)'(1);
                2'b01:   r_fill <= r_fill - (AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_en_rise) begin
                r_overflow   <= 1'b0;
                r_byte_count <= 16'h0000;
            end else begin
                if (w_push && !w_accept) begin
                    r_overflow <= 1'b1;
                end
                if (w_accept) begin
                    r_byte_count <= r_byte_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lynx_tape_rec.sv
// tb/tb_lynx_tape_rec.sv - scoreboard bench for the tape recorder decoder
`timescale 1ns/1ps
module tb_lynx_tape_rec;
    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        mic     = 1'b0;
    wire         rec_ready;
    logic [7:0]  rec_data;
    logic        rec_valid;
    logic        rec_gap;
    logic        overflow;
    logic [15:0] byte_count;

    int   rdy_mode = 0;
    logic rnd_rdy  = 1'b0;
    assign rec_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

    int n_chk = 0;
    int n_fail = 0;
    int gap_pulses = 0;
    int exp_count = 0;
    int used = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hold_d = 8'h00;
    bit hold_v = 1'b0;

    lynx_tape_rec #(.MIN_CYC(16), .THR_CYC(200), .GAP_CYC(4000), .FIFO_DEPTH(16)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable), .mic(mic),
        .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_gap(rec_gap), .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) rnd_rdy <= 1'($urandom_range(0, 1));

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (rec_gap) gap_pulses++;
            if (hold_v && rec_valid) check("hold_stable", rec_data, hold_d);
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got byte 0x%0h, expected none", rec_data);
                end else begin
                    check("pop_data", rec_data, exp_q.pop_front());
                end
            end
            hold_v = rec_valid && !rec_ready;
            hold_d = rec_data;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Rising MIC edge s clocks after the previous one; optional 5-clock glitch
    // or a one-cycle ready window aligned with the resulting FIFO push.
    task automatic edge_at(int s, bit glitch, bit pop_at_push);
        if (s > used) tick(s - used);
        mic = 1'b1;
        if (pop_at_push) begin
            tick(2); mic = 1'b0; tick(1);
            rdy_mode = 1; tick(1); rdy_mode = 0;
            used = 4;
        end else begin
            tick(2); mic = 1'b0; used = 2;
            if (glitch) begin
                tick(3); mic = 1'b1; tick(2); mic = 1'b0; used = 7;
            end
        end
    endtask

    task automatic send_bit(bit b, bit glitch, bit pp);
        int s;
        s = b ? int'($urandom_range(215, 280)) : int'($urandom_range(24, 180));
        edge_at(s, glitch, pp);
    endtask

    task automatic send_byte(logic [7:0] v, bit glitch, bit accept, bit pp);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], glitch && (i == 5 || i == 2), pp && (i == 0));
        if (accept) begin
            exp_q.push_back(v);
            exp_count++;
        end
    endtask

    task automatic start_stream();
        enable = 1'b0; tick(2);
        enable = 1'b1; tick(2);
        exp_count = 0;
        used = 0;
        edge_at(30, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(int max);
        int k = 0;
        while (exp_q.size() != 0 && k < max) begin
            tick(1);
            k++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp[8] = '{100, 300, 100, 300, 100, 100, 300, 300};
        int g0;
        logic [7:0] v;

        tick(3);
        check("rst_valid", rec_valid, 0);
        check("rst_data", rec_data, 0);
        check("rst_gap", rec_gap, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", byte_count, 0);
        reset = 1'b0;
        tick(1);
        check("post_rst_valid", rec_valid, 0);

        // Fixed pattern 0,1,0,1,0,0,1,1.
        rdy_mode = 0;
        start_stream();
        for (int i = 0; i < 8; i++) edge_at(sp[i], 1'b0, 1'b0);
        exp_q.push_back(8'h53); exp_count++;
        tick(4);
        check("fixed_valid", rec_valid, 1);
        check("fixed_data", rec_data, 8'h53);
        check("fixed_count", byte_count, exp_count);
        rdy_mode = 2;
        wait_drain(200);

        // Glitch edges inside bytes.
        start_stream();
        for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1'b1, 1'b1, 1'b0);
        tick(4);
        check("glitch_count", byte_count, exp_count);
        wait_drain(200);

        // Gap after three bits.
        start_stream();
        g0 = gap_pulses;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 1'b0);
        tick(4200 - used);
        check("gap_pulses", gap_pulses - g0, 1);
        used = 0;
        edge_at(30, 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
        tick(4);
        check("gap_count", byte_count, exp_count);
        check("gap_no_extra", gap_pulses - g0, 1);
        wait_drain(200);

        // Enable drop mid-byte keeps FIFO content, no gap pulse.
        rdy_mode = 0;
        start_stream();
        v = 8'($urandom);
        send_byte(v, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 1'b0);
        g0 = gap_pulses;
        enable = 1'b0;
        tick(6);
        check("endrop_valid", rec_valid, 1);
        check("endrop_data", rec_data, v);
        check("endrop_gap", gap_pulses - g0, 0);
        rdy_mode = 2;
        start_stream();
        send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
        tick(4);
        check("endrop_count", byte_count, exp_count);
        wait_drain(200);

        // Random bytes with random back-pressure.
        start_stream();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
        tick(4);
        check("rand_count", byte_count, exp_count);
        wait_drain(200);

        // Overflow: 17 bytes with no consumer.
        rdy_mode = 0;
        start_stream();
        for (int i = 0; i < 17; i++) send_byte(8'($urandom), 1'b0, i < 16, 1'b0);
        tick(4);
        check("ovf_flag", overflow, 1);
        check("ovf_count", byte_count, 16);
        check("ovf_head", rec_data, exp_q[0]);
        rdy_mode = 2;
        wait_drain(300);

        // Full FIFO with a pop in the push cycle, then a dropped byte.
        rdy_mode = 0;
        start_stream();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
        tick(4);
        check("full_ovf0", overflow, 0);
        check("full_count16", byte_count, 16);
        send_byte(8'($urandom), 1'b0, 1'b1, 1'b1);
        tick(4);
        check("simul_ovf", overflow, 0);
        check("simul_count", byte_count, 17);
        send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        tick(4);
        check("drop_ovf", overflow, 1);
        check("drop_count", byte_count, 17);
        rdy_mode = 2;
        wait_drain(300);

        // Reset mid-byte with two bytes queued.
        rdy_mode = 0;
        start_stream();
        for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1'b0);
        tick(4);
        check("prerst_valid", rec_valid, 1);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", rec_valid, 0);
        check("rst_mid_count", byte_count, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
        check("after_rst_valid", rec_valid, 0);
        check("after_rst_data", rec_data, 0);
        check("after_rst_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lynx_tape_rec.md
LYNX_TAPE_REC -- requirements
Module: lynx_tape_rec

Interface
REQ-001 SHALL have parameter MIN_CYC, default 16: edge spacing in clocks below which a rising edge is treated as a glitch.
REQ-002 SHALL have parameter THR_CYC, default 200: spacing below which a period decodes as bit 0; at or above it, as bit 1.
REQ-003 SHALL have parameter GAP_CYC, default 4000: edge-free interval that marks a block gap.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: output byte FIFO depth, a power of two.
REQ-005 SHALL have port clk_sys, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: recording armed.
REQ-008 SHALL have port mic, input, 1 bit: cassette output from the core; asynchronous to clk_sys.
REQ-009 SHALL have port rec_data, output, 8 bits: FIFO head byte.
REQ-010 SHALL have port rec_valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port rec_ready, input, 1 bit: consumer accepts rec_data.
REQ-012 SHALL have port rec_gap, output, 1 bit: one-cycle pulse per gap detected.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; a byte was dropped.
REQ-014 SHALL have port byte_count, output, 16 bits: bytes accepted into the FIFO.

Function
REQ-015 SHALL synchronize mic through two flops and detect rising edges on the synchronized value; edge-detect latency is 3 clocks.
REQ-016 SHALL implement states IDLE, SYNC and RUN.
REQ-017 IDLE, on enable=0: period counter cleared, shift register cleared, bit count cleared.
REQ-018 Enable rising edge SHALL move the block to SYNC and clear overflow and byte_count.
REQ-019 SYNC, on first rising edge: clear the period counter and move to RUN; no bit is produced.
REQ-020 RUN: the 16-bit period counter C increments every clock and saturates at 0xFFFF.
REQ-021 RUN, rising edge with C<MIN_CYC: edge ignored; C not cleared.
REQ-022 RUN, rising edge with MIN_CYC<=C<THR_CYC: shift in 0, then clear C.
REQ-023 RUN, rising edge with C>=THR_CYC (and C<GAP_CYC): shift in 1, then clear C.
REQ-024 Bits SHALL be assembled MSB first; the 8th bit completes the byte and resets the bit count to 0.
REQ-025 A completed byte SHALL be pushed into the FIFO; rec_valid rises 1 clock after the completing edge is detected.
REQ-026 RUN, when C reaches GAP_CYC with no edge: discard partial bits, pulse rec_gap for 1 clock, move to SYNC.
REQ-027 Pop SHALL occur on rec_valid && rec_ready; rec_data SHALL be stable while rec_valid=1 and rec_ready=0.
REQ-028 Push when full with no simultaneous pop: byte dropped, overflow set, byte_count unchanged.
REQ-029 Simultaneous push and pop when full: both occur; no overflow.
REQ-030 byte_count SHALL increment per accepted byte and wrap from 0xFFFF to 0.
REQ-031 Enable falling mid-byte: partial bits discarded, go to IDLE; FIFO contents retained and drainable; rec_gap not pulsed.

Reset
REQ-032 On reset: state IDLE; FIFO empty; rec_valid=0, rec_data=0, rec_gap=0, overflow=0, byte_count=0; synchronizer flops 0.
REQ-033 A byte in flight SHALL be lost on reset; outputs SHALL be valid from the first clock after reset deasserts.

Verification
REQ-034 enable=1; mic edges spaced 100,300,100,300,100,100,300,300 clocks after the sync edge -> rec_data=0x53, rec_valid=1, byte_count=1.
REQ-035 Extra rising edge 5 clocks after a valid edge inside a byte -> ignored; decoded byte unchanged.
REQ-036 3 bits sent, then mic held 4000 clocks -> rec_gap pulses once; next 8 bits decode as a fresh byte.
REQ-037 rec_ready=0, 17 bytes sent -> 16 bytes held, overflow=1, byte_count=16; draining yields the first 16 bytes in order.
REQ-038 Full FIFO, rec_ready=1 during the 17th byte push -> overflow=0, byte_count=17.
REQ-039 Reset asserted mid-byte with 2 bytes queued -> rec_valid=0 and byte_count=0 within the same cycle.
